// File: rtl/gpu_inst_pkg.sv
// gpu_inst_pkg: shared types, constants and instruction-word field offsets for the 2D GPU instruction decoder
package gpu_inst_pkg;
  typedef enum logic [1:0] {IDLE, READ, CAPTURE, OUT} state_t;
  localparam logic INST_DRAW = 1'b0;
  localparam logic INST_ALPHA = 1'b1;
  localparam logic FILL_SOLID = 1'b0;
  localparam logic FILL_TEX = 1'b1;
  localparam int COORD_OFF = 2;
  function automatic int layer_off(int coord_w, int max_verts);
    return COORD_OFF + max_verts * coord_w;
  endfunction
  function automatic int fill_off(int coord_w, int max_verts, int layer_w);
    return layer_off(coord_w, max_verts) + layer_w;
  endfunction
  function automatic int color_off(int coord_w, int max_verts, int layer_w);
    return fill_off(coord_w, max_verts, layer_w) + 1;
  endfunction
  function automatic int tex_off(int coord_w, int max_verts, int layer_w, int color_w);
    return color_off(coord_w, max_verts, layer_w) + color_w;
  endfunction
  function automatic int alpha_off(int coord_w, int max_verts, int layer_w, int color_w, int tex_w);
    return tex_off(coord_w, max_verts, layer_w, color_w) + tex_w;
  endfunction
  function automatic int inst_w(int coord_w, int max_verts, int layer_w, int color_w, int tex_w, int alpha_w);
    return alpha_off(coord_w, max_verts, layer_w, color_w, tex_w) + alpha_w;
  endfunction
endpackage

// File: rtl/gpu_inst_fields.sv
// gpu_inst_fields: combinational slicer from an instruction word to draw-command fields
// Ports: word (instruction in); inst_type, new_alpha (alpha-instruction payload);
// coordinates, vertice_num, layer_num, fill_type, color_code, texture_code, alpha_field (draw fields).
module gpu_inst_fields
  import gpu_inst_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int MAX_VERTS = 3,
  parameter int LAYER_W = 1,
  parameter int COLOR_W = 24,
  parameter int TEX_W = 2,
  parameter int ALPHA_W = 4,
  localparam int INST_W = inst_w(COORD_W, MAX_VERTS, LAYER_W, COLOR_W, TEX_W, ALPHA_W)
) (
  input  logic [INST_W-1:0]            word,
  output logic                         inst_type,
  output logic [ALPHA_W-1:0]           new_alpha,
  output logic [MAX_VERTS*COORD_W-1:0] coordinates,
  output logic                         vertice_num,
  output logic [LAYER_W-1:0]           layer_num,
  output logic                         fill_type,
  output logic [COLOR_W-1:0]           color_code,
  output logic [TEX_W-1:0]             texture_code,
  output logic [ALPHA_W-1:0]           alpha_field
);
  localparam int CW_ALL = MAX_VERTS * COORD_W;
  localparam int FILL_OFF = fill_off(COORD_W, MAX_VERTS, LAYER_W);
  logic [CW_ALL-1:0] raw;
  assign raw = word[COORD_OFF +: CW_ALL];
  assign inst_type = word[0];
  assign new_alpha = word[ALPHA_W:1];
  assign vertice_num = word[1];
  // Two-vertex primitives keep only the lowest two vertex slots.
  assign coordinates = vertice_num ? raw : raw & ~({CW_ALL{1'b1}} << (2 * COORD_W));
  assign layer_num = word[layer_off(COORD_W, MAX_VERTS) +: LAYER_W];
  assign fill_type = word[FILL_OFF];
  assign color_code = fill_type == FILL_SOLID ? word[color_off(COORD_W, MAX_VERTS, LAYER_W) +: COLOR_W] : '0;
  assign texture_code = fill_type == FILL_TEX ? word[tex_off(COORD_W, MAX_VERTS, LAYER_W, COLOR_W) +: TEX_W] : '0;
  assign alpha_field = word[alpha_off(COORD_W, MAX_VERTS, LAYER_W, COLOR_W, TEX_W) +: ALPHA_W];
endmodule

// File: rtl/gpu_inst_decoder.sv
// gpu_inst_decoder: pops instruction words from the FIFO and presents registered draw commands on valid/ready
// Ports: clk, n_rst (async active-low); fifo_empty/fifo_rd/fifo_data (FIFO side);
// cmd_valid/cmd_ready plus command fields (rasteriser side); global_alpha (sticky alpha register).
module gpu_inst_decoder
  import gpu_inst_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int MAX_VERTS = 3,
  parameter int LAYER_W = 1,
  parameter int COLOR_W = 24,
  parameter int TEX_W = 2,
  parameter int ALPHA_W = 4,
  localparam int INST_W = inst_w(COORD_W, MAX_VERTS, LAYER_W, COLOR_W, TEX_W, ALPHA_W)
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         fifo_empty,
  output logic                         fifo_rd,
  input  logic [INST_W-1:0]            fifo_data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [MAX_VERTS*COORD_W-1:0] coordinates,
  output logic                         vertice_num,
  output logic [LAYER_W-1:0]           layer_num,
  output logic                         fill_type,
  output logic [COLOR_W-1:0]           color_code,
  output logic [TEX_W-1:0]             texture_code,
  output logic [ALPHA_W-1:0]           alpha_val,
  output logic [ALPHA_W-1:0]           global_alpha
);
  state_t state, next_state;
  logic                         f_type;
  logic [ALPHA_W-1:0]           f_new_alpha;
  logic [MAX_VERTS*COORD_W-1:0] f_coords;
  logic                         f_vnum;
  logic [LAYER_W-1:0]           f_layer;
  logic                         f_fill;
  logic [COLOR_W-1:0]           f_color;
  logic [TEX_W-1:0]             f_tex;
  logic [ALPHA_W-1:0]           f_alpha;
  gpu_inst_fields #(
    .COORD_W(COORD_W), .MAX_VERTS(MAX_VERTS), .LAYER_W(LAYER_W),
    .COLOR_W(COLOR_W), .TEX_W(TEX_W), .ALPHA_W(ALPHA_W)
  ) u_fields (
    .word(fifo_data), .inst_type(f_type), .new_alpha(f_new_alpha),
    .coordinates(f_coords), .vertice_num(f_vnum), .layer_num(f_layer),
    .fill_type(f_fill), .color_code(f_color), .texture_code(f_tex),
    .alpha_field(f_alpha)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE ? (fifo_empty ? IDLE : READ) :
                 state == READ ? CAPTURE :
                 state == CAPTURE ? (f_type == INST_ALPHA ? IDLE : OUT) :
                 (cmd_ready ? IDLE : OUT);
  always_comb begin
    fifo_rd = state == READ;
    cmd_valid = state == OUT;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      coordinates <= '0;
      vertice_num <= 1'b0;
      layer_num <= '0;
      fill_type <= 1'b0;
      color_code <= '0;
      texture_code <= '0;
      alpha_val <= '0;
      global_alpha <= '1;
    end else if (state == CAPTURE) begin
      if (f_type == INST_ALPHA) global_alpha <= f_new_alpha;
      else begin
        coordinates <= f_coords;
        vertice_num <= f_vnum;
        layer_num <= f_layer;
        fill_type <= f_fill;
        color_code <= f_color;
        texture_code <= f_tex;
        // A zero alpha field inherits the sticky alpha as it stood before this word.
        alpha_val <= f_alpha != '0 ? f_alpha : global_alpha;
      end
    end
endmodule

// File: tb/tb_gpu_inst_decoder.sv
// tb_gpu_inst_decoder: randomized scoreboard bench for gpu_inst_decoder at default parameters
module tb_gpu_inst_decoder;
  typedef struct packed {
    logic [47:0] c;
    logic        vn;
    logic        layer;
    logic        fill;
    logic [23:0] col;
    logic [1:0]  tex;
    logic [3:0]  a;
    logic [3:0]  ga;
  } cmd_t;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [81:0] fifo_data = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [47:0] coordinates;
  logic        vertice_num;
  logic [0:0]  layer_num;
  logic        fill_type;
  logic [23:0] color_code;
  logic [1:0]  texture_code;
  logic [3:0]  alpha_val;
  logic [3:0]  global_alpha;
  logic [81:0] q[$];
  cmd_t        expq[$];
  logic [3:0]  model_ga = 4'hF;
  bit          hold_low = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          rd_age = 99;
  bit          prev_rd = 1'b0;
  bit          prev_valid = 1'b0;
  gpu_inst_decoder dut (
    .clk(clk), .n_rst(n_rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_data(fifo_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .coordinates(coordinates), .vertice_num(vertice_num), .layer_num(layer_num),
    .fill_type(fill_type), .color_code(color_code), .texture_code(texture_code),
    .alpha_val(alpha_val), .global_alpha(global_alpha)
  );
  always #5 clk = ~clk;
  function automatic cmd_t model(input logic [81:0] w, input logic [3:0] ga);
    cmd_t e;
    int nv;
    e = '0;
    nv = w[1] ? 3 : 2;
    for (int v = 0; v < nv; v++) e.c[v*16 +: 16] = w[2 + v*16 +: 16];
    e.vn = w[1];
    e.layer = w[50];
    e.fill = w[51];
    if (!w[51]) e.col = w[52 +: 24];
    else e.tex = w[76 +: 2];
    e.a = w[78 +: 4] != 4'h0 ? w[78 +: 4] : ga;
    e.ga = ga;
    return e;
  endfunction
  function automatic logic [81:0] mk_draw(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                                          input logic vsel, input logic layer, input logic fill,
                                          input logic [23:0] color, input logic [1:0] tex, input logic [3:0] a);
    logic [81:0] w;
    w = '0;
    w[1] = vsel;
    w[2 +: 16] = c0;
    w[18 +: 16] = c1;
    w[34 +: 16] = c2;
    w[50] = layer;
    w[51] = fill;
    w[52 +: 24] = color;
    w[76 +: 2] = tex;
    w[78 +: 4] = a;
    return w;
  endfunction
  function automatic logic [81:0] rand_word();
    return 82'({$urandom(), $urandom(), $urandom()});
  endfunction
  task automatic push(input logic [81:0] w);
    q.push_back(w);
    if (w[0]) model_ga = w[4:1];
    else expq.push_back(model(w, model_ga));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || expq.size() != 0 || cmd_valid) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: %0d words and %0d commands still pending", q.size(), expq.size());
    end
    repeat (3) tick();
  endtask
  always @(negedge clk) begin
    if (n_rst && fifo_rd && q.size() != 0) fifo_data = q.pop_front();
    fifo_empty = q.size() == 0;
  end
  always @(posedge clk) begin
    #1;
    cmd_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
  end
  always @(negedge clk) begin
    if (n_rst) begin
      rd_age = fifo_rd ? 0 : rd_age + 1;
      if (fifo_rd) begin
        checks++;
        if (prev_rd || cmd_valid) begin
          errors++;
          $display("FAIL rd_pulse: fifo_rd high with prev_rd=%0d cmd_valid=%0d, expected single pulse outside OUT", prev_rd, cmd_valid);
        end
      end
      if (cmd_valid) begin
        if (!prev_valid) begin
          checks++;
          if (rd_age != 2) begin
            errors++;
            $display("FAIL valid_latency: cmd_valid %0d cycles after fifo_rd, expected 2", rd_age);
          end
        end
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd: cmd_valid with no command expected");
        end else begin
          cmd_t act;
          act = {coordinates, vertice_num, layer_num, fill_type, color_code, texture_code, alpha_val, global_alpha};
          if (act !== expq[0]) begin
            errors++;
            $display("FAIL cmd_fields: got %h expected %h", act, expq[0]);
          end
          if (cmd_ready) void'(expq.pop_front());
        end
      end
      prev_rd = fifo_rd;
      prev_valid = cmd_valid;
    end else begin
      prev_rd = 1'b0;
      prev_valid = 1'b0;
    end
  end
  initial begin
    int n;
    logic [81:0] w;
    repeat (3) tick();
    check("reset_valid", 128'(cmd_valid), 128'(0));
    check("reset_rd", 128'(fifo_rd), 128'(0));
    check("reset_ga", 128'(global_alpha), 128'(4'hF));
    n_rst = 1'b1;
    tick();
    push(mk_draw(16'h1122, 16'h3344, 16'h5566, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 2'b11, 4'h7));
    wait_drain();
    push(mk_draw(16'hA1A1, 16'hB2B2, 16'hFFFF, 1'b0, 1'b0, 1'b1, 24'h123456, 2'b10, 4'h3));
    wait_drain();
    w = rand_word();
    w[4:0] = {4'h5, 1'b1};
    push(w);
    push(mk_draw(16'h0001, 16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0, 24'h00FF00, 2'b00, 4'h0));
    wait_drain();
    check("ga_after_alpha", 128'(global_alpha), 128'(4'h5));
    hold_low = 1'b1;
    push(mk_draw(16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b1, 1'b1, 24'h0, 2'b01, 4'h9));
    push(mk_draw(16'h4444, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0, 24'hC0FFEE, 2'b00, 4'hA));
    n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check("stall_valid", 128'(cmd_valid), 128'(1));
    check("stall_no_pop", 128'(q.size()), 128'(1));
    hold_low = 1'b0;
    wait_drain();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_rd || cmd_valid) begin
        checks++;
        errors++;
        $display("FAIL empty_idle: fifo_rd=%0d cmd_valid=%0d, expected 0 0", fifo_rd, cmd_valid);
      end
    end
    check("empty_idle", 128'({fifo_rd, cmd_valid}), 128'(0));
    for (int i = 0; i < 200; i++) begin
      w = rand_word();
      w[0] = $urandom_range(0, 3) == 0;
      push(w);
      repeat ($urandom_range(0, 4)) tick();
    end
    wait_drain();
    check("ga_after_random", 128'(global_alpha), 128'(model_ga));
    hold_low = 1'b1;
    push(mk_draw(16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b0, 24'h777777, 2'b00, 4'h2));
    n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    check("pre_reset_valid", 128'(cmd_valid), 128'(1));
    n_rst = 1'b0;
    #1;
    check("async_rst_valid", 128'(cmd_valid), 128'(0));
    check("async_rst_fields", 128'({coordinates, vertice_num, layer_num, fill_type, color_code, texture_code, alpha_val}), 128'(0));
    check("async_rst_ga", 128'(global_alpha), 128'(4'hF));
    q.delete();
    expq.delete();
    model_ga = 4'hF;
    hold_low = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    push(mk_draw(16'h0F0F, 16'hF0F0, 16'h1234, 1'b0, 1'b1, 1'b0, 24'h010203, 2'b01, 4'h0));
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
